// File: rtl/scan_seq_3x8.sv
// -----------------------------------------------------------------------------
// scan_seq_3x8
//   Line sequencer feeding a 3-to-8 one-hot decoder. Walks the 3-bit line
//   select through the set bits of a latched mask in ascending order, holding
//   each line for a programmable dwell time, and pulses line/frame completion.
//
// Configuration macro:
//   SCAN_GAP_EN  when defined, one dead (GAP) cycle with dec_en=0 is inserted
//                after every line except at the end of a single frame.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous active-high reset
//   start       in   1        request a scan (honoured only in IDLE)
//   stop        in   1        abort scan (honoured in any state, beats start)
//   loop        in   1        1 = continuous frames, sampled with start
//   dwell       in   DWELL_W  cycles per line, 0 behaves as 1
//   mask        in   8        bit i set -> line i is visited
//   sel         out  3        line select {a,x,y}
//   dec_en      out  1        decoder enable, high only while a line is active
//   busy        out  1        high from accepted start until back in IDLE
//   line_done   out  1        pulse on the last active cycle of each line
//   frame_done  out  1        pulse on the last active cycle of a frame
// -----------------------------------------------------------------------------
module scan_seq_3x8 #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               dec_en,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;   // latched dwell, already reduced by one
    logic               loop_q;
    logic [DWELL_W-1:0] cnt;       // cycles remaining on the current line after this one

    // Lowest set bit of a mask (0 when empty; callers guard the empty case).
    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    // Next set bit strictly above cur (returns cur when none exists).
    function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        next_above = cur;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i > int'(cur))) next_above = 3'(i);
    endfunction

    // True when no set bit lies above cur, i.e. cur is the frame's last line.
    function automatic logic none_above(input logic [7:0] m, input logic [2:0] cur);
        none_above = 1'b1;
        for (int i = 0; i < 8; i++)
            if (m[i] && (i > int'(cur))) none_above = 1'b0;
    endfunction

    logic [DWELL_W-1:0] dwell_in_m1;
    logic [2:0]         wrap_line;
    logic               wrap_last;
    logic [2:0]         nxt_line;
    logic               cur_last;

    // A dwell of 0 is run as a single cycle, so store dwell-1 saturated at 0.
    assign dwell_in_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign wrap_line   = lowest(mask);
    assign wrap_last   = none_above(mask, wrap_line);
    assign nxt_line    = next_above(mask_q, sel);
    assign cur_last    = none_above(mask_q, sel);

`ifndef SCAN_GAP_EN
    logic nxt_last;
    assign nxt_last = none_above(mask_q, nxt_line);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 3'd0;
            dec_en     <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            mask_q     <= 8'd0;
            dwell_q    <= '0;
            loop_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            // Completion flags are single-cycle unless re-armed below.
            line_done  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !stop && (mask != 8'd0)) begin
                        mask_q     <= mask;
                        dwell_q    <= dwell_in_m1;
                        loop_q     <= loop;
                        sel        <= wrap_line;
                        dec_en     <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= dwell_in_m1;
                        line_done  <= (dwell_in_m1 == '0);
                        frame_done <= (dwell_in_m1 == '0) && wrap_last;
                        state      <= SCAN;
                    end
                end

                SCAN: begin
                    if (stop) begin
                        dec_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        // Flags are registered, so arm them one cycle before the line's last cycle.
                        cnt        <= cnt - DWELL_W'(1);
                        line_done  <= (cnt == DWELL_W'(1));
                        frame_done <= (cnt == DWELL_W'(1)) && cur_last;
                    end else if (!cur_last) begin
                        sel <= nxt_line;
`ifdef SCAN_GAP_EN
                        dec_en <= 1'b0;
                        state  <= GAP;
`else
                        cnt        <= dwell_q;
                        line_done  <= (dwell_q == '0);
                        frame_done <= (dwell_q == '0) && nxt_last;
`endif
                    end else if (loop_q && (mask != 8'd0)) begin
                        // Frame wrap: the next frame runs on freshly sampled mask and dwell.
                        mask_q  <= mask;
                        dwell_q <= dwell_in_m1;
                        sel     <= wrap_line;
`ifdef SCAN_GAP_EN
                        dec_en <= 1'b0;
                        state  <= GAP;
`else
                        cnt        <= dwell_in_m1;
                        line_done  <= (dwell_in_m1 == '0);
                        frame_done <= (dwell_in_m1 == '0) && wrap_last;
`endif
                    end else begin
                        // Single frame finished (or looping with an empty mask): sel holds.
                        dec_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end

`ifdef SCAN_GAP_EN
                GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // sel already points at the upcoming line; mask_q/dwell_q are current.
                        dec_en     <= 1'b1;
                        cnt        <= dwell_q;
                        line_done  <= (dwell_q == '0);
                        frame_done <= (dwell_q == '0) && cur_last;
                        state      <= SCAN;
                    end
                end
`endif

                default: begin
                    dec_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq_3x8.sv
// -----------------------------------------------------------------------------
// tb_scan_seq_3x8
//   Self-checking bench for scan_seq_3x8. A reference model expands each frame
//   into a per-cycle list of expected outputs, built directly from the line
//   ordering and dwell rules; the bench then compares the DUT cycle by cycle.
//   Honors SCAN_GAP_EN in the model when the macro is defined.
// -----------------------------------------------------------------------------
module tb_scan_seq_3x8;

    typedef struct packed {
        logic [2:0] sel;
        logic       dec_en;
        logic       busy;
        logic       line_done;
        logic       frame_done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] mask = 8'd0;
    logic [2:0] sel;
    logic       dec_en, busy, line_done, frame_done;

    obs_t       dut_o;
    obs_t       exp_q[$];
    logic [2:0] last_sel = 3'd0;
    int         checks = 0;
    int         errors = 0;

    scan_seq_3x8 #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .dwell     (dwell),
        .mask      (mask),
        .sel       (sel),
        .dec_en    (dec_en),
        .busy      (busy),
        .line_done (line_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always_comb dut_o = {sel, dec_en, busy, line_done, frame_done};

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed sel=%0d en=%b busy=%b ld=%b fd=%b expected sel=%0d en=%b busy=%b ld=%b fd=%b",
                   tag, obs.sel, obs.dec_en, obs.busy, obs.line_done, obs.frame_done,
                   exp.sel, exp.dec_en, exp.busy, exp.line_done, exp.frame_done);
        end
    endtask

    function automatic int lo_bit(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int hi_bit(input logic [7:0] m);
        for (int i = 7; i >= 0; i--) if (m[i]) return i;
        return 0;
    endfunction

    // Expected cycles of one frame: every visited line appears dwell times in
    // ascending order; wraps says another frame (mask next_m) follows.
    function automatic void add_frame(input logic [7:0] m, input int d,
                                      input logic [7:0] next_m, input bit wraps);
        int   deff = (d == 0) ? 1 : d;
        int   last = hi_bit(m);
        obs_t r;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                for (int c = 0; c < deff; c++) begin
                    r.sel        = 3'(i);
                    r.dec_en     = 1'b1;
                    r.busy       = 1'b1;
                    r.line_done  = (c == deff - 1);
                    r.frame_done = (c == deff - 1) && (i == last);
                    exp_q.push_back(r);
                end
`ifdef SCAN_GAP_EN
                if (i != last || wraps) begin
                    r = '0;
                    r.busy = 1'b1;
                    if (i != last) begin
                        for (int j = 7; j > i; j--) if (m[j]) r.sel = 3'(j);
                    end else begin
                        r.sel = 3'(lo_bit(next_m));
                    end
                    exp_q.push_back(r);
                end
`endif
            end
        end
        if (wraps && next_m == 8'd0) exp_q.push_back('0);  // unused by callers
    endfunction

    function automatic void add_idle(input logic [2:0] s, input int n);
        obs_t r = '0;
        r.sel = s;
        for (int k = 0; k < n; k++) exp_q.push_back(r);
    endfunction

    // Called on a negedge; sets inputs for a start that is sampled on the next edge.
    task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic lp);
        mask  = m;
        dwell = d;
        loop  = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compare queued expectations, one per cycle. stop_at > 0 raises stop during
    // that record's cycle and abandons the rest; noise scrambles the inputs that
    // must have no effect while busy.
    task automatic run_q(input string tag, input int max_n, input int stop_at, input bit noise);
        int   n = 0;
        obs_t r;
        while (exp_q.size() > 0 && n < max_n) begin
            r = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, n), dut_o, r);
            last_sel = r.sel;
            n++;
            if (noise) begin
                start = r.busy ? 1'($urandom) : 1'b0;
                mask  = 8'($urandom);
                dwell = 8'($urandom);
            end
            if (n == stop_at) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] m;
        int         d;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset", dut_o, '0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle", dut_o, '0);

        // Full mask, dwell 2, single frame
        do_start(8'hFF, 8'd2, 1'b0);
        add_frame(8'hFF, 2, 8'h00, 1'b0);
        add_idle(3'd7, 2);
        run_q("t1_ff", 1000, 0, 1'b0);

        // Sparse mask: lines 2,5,7
        do_start(8'hA4, 8'd3, 1'b0);
        add_frame(8'hA4, 3, 8'h00, 1'b0);
        add_idle(3'd7, 2);
        run_q("t2_a4", 1000, 0, 1'b0);

        // Dwell 0 behaves as 1
        do_start(8'h81, 8'd0, 1'b0);
        add_frame(8'h81, 0, 8'h00, 1'b0);
        add_idle(3'd7, 2);
        run_q("t3_d0", 1000, 0, 1'b0);

        // Looping with a mask change mid-frame, stop during cycle 7
        do_start(8'h03, 8'd1, 1'b1);
        mask = 8'h04;
        add_frame(8'h03, 1, 8'h04, 1'b1);
        for (int k = 0; k < 8; k++) add_frame(8'h04, 1, 8'h04, 1'b1);
        run_q("t4_loop", 1000, 7, 1'b0);
        loop = 1'b0;
        add_idle(last_sel, 3);
        run_q("t4_stopped", 1000, 0, 1'b0);

        // Reset in the middle of line 4
        do_start(8'h10, 8'd5, 1'b0);
        add_frame(8'h10, 5, 8'h00, 1'b0);
        run_q("t5_pre_rst", 2, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst", dut_o, '0);
        rst = 1'b0;
        last_sel = 3'd0;
        @(negedge clk);
        check("t5_rst_idle", dut_o, '0);

        // Start with an empty mask is ignored
        mask  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        add_idle(last_sel, 2);
        run_q("t5_mask0", 1000, 0, 1'b0);

        // Stop and start together: stop wins
        mask  = 8'hFF;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        add_idle(last_sel, 2);
        run_q("start_stop", 1000, 0, 1'b0);

        // Randomized single frames with junk on start/mask/dwell while busy
        for (int it = 0; it < 25; it++) begin
            m = 8'($urandom);
            d = $urandom_range(0, 4);
            if (m == 8'd0) begin
                mask  = 8'd0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                add_idle(last_sel, 1);
            end else begin
                do_start(m, 8'(d), 1'b0);
                add_frame(m, d, 8'h00, 1'b0);
                add_idle(3'(hi_bit(m)), 1);
            end
            run_q($sformatf("rnd%0d", it), 1000, 0, 1'b1);
        end

        // Randomized stop point inside a single frame
        m = 8'($urandom) | 8'h01;
        do_start(m, 8'd2, 1'b0);
        add_frame(m, 2, 8'h00, 1'b0);
        run_q("rnd_stop", 1000, $urandom_range(1, 2), 1'b0);
        add_idle(last_sel, 2);
        run_q("rnd_stopped", 1000, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
